// File: rtl/lwe_encrypt_accum_if.sv
// Beat-in / row-result-out bundle for the LWE accumulator; master is the producer side.
// Both directions use valid/ready; in_* carries lane beats, out_* carries reduced rows.
interface lwe_encrypt_accum_if #(
  parameter int LANES     = 2,
  parameter int CT_WIDTH  = 32,
  parameter int Q_WIDTH   = 10,
  parameter int ROW_WIDTH = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*CT_WIDTH-1:0] in_data;
  logic [LANES-1:0]          in_mask;
  logic [ROW_WIDTH-1:0]      in_row;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [Q_WIDTH-1:0]        out_data;
  logic [ROW_WIDTH-1:0]      out_row;
  logic                      out_last;

  modport master (
    output in_valid, in_data, in_mask, in_row, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_last
  );

  modport slave (
    input  in_valid, in_data, in_mask, in_row, in_last, out_ready,
    output in_ready, out_valid, out_data, out_row, out_last
  );
endinterface

// File: rtl/lwe_encrypt_accum.sv
// Streaming LWE row accumulator: sums masked lane words mod 2^Q, adds scaled pt on the b row.
// Row result appears one cycle after the closing beat; single output register, in_ready drops while it is held.
module lwe_encrypt_accum #(
  parameter int LANES     = 2,
  parameter int CT_WIDTH  = 32,
  parameter int Q_WIDTH   = 10,
  parameter int PT_WIDTH  = 6,
  parameter int ROWS      = 129,
  parameter int ROW_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [PT_WIDTH-1:0] pt,
  lwe_encrypt_accum_if.slave  bus,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

  typedef struct packed {
    logic [Q_WIDTH-1:0]   data;
    logic [ROW_WIDTH-1:0] row;
    logic                 last;
  } res_t;

  localparam logic [ROW_WIDTH-1:0] B_ROW = ROW_WIDTH'(ROWS - 1);

  state_t               state_q, state_d;
  logic [Q_WIDTH-1:0]   acc_q;
  logic [ROW_WIDTH-1:0] row_q;
  logic [PT_WIDTH-1:0]  pt_q;
  logic                 err_q;
  logic                 out_vld_q;
  res_t                 res_q;

  logic [Q_WIDTH-1:0]   beat_sum;
  logic [Q_WIDTH-1:0]   acc_next;
  logic [Q_WIDTH-1:0]   pt_scaled;
  logic                 accept, row_ok, close, is_b, out_hs;

  // Lane bits above Q_WIDTH cannot affect a mod-2^Q sum.
  logic unused_lane_bits;
  assign unused_lane_bits = ^bus.in_data;

  always_comb begin
    beat_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      if (bus.in_mask[k]) beat_sum = beat_sum + bus.in_data[k*CT_WIDTH +: Q_WIDTH];
    end
  end

  assign pt_scaled = {pt_q, {(Q_WIDTH-PT_WIDTH){1'b0}}};
  assign acc_next  = acc_q + beat_sum;
  assign accept    = bus.in_valid && bus.in_ready;
  assign row_ok    = (bus.in_row == row_q);
  assign close     = accept && row_ok && bus.in_last;
  assign is_b      = (row_q == B_ROW);
  assign out_hs    = out_vld_q && bus.out_ready;

  assign bus.in_ready  = (state_q == ACCUM) && (!out_vld_q || bus.out_ready);
  assign bus.out_valid = out_vld_q;
  assign bus.out_data  = res_q.data;
  assign bus.out_row   = res_q.row;
  assign bus.out_last  = res_q.last;
  assign busy          = (state_q != IDLE);
  assign err           = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = ACCUM;
      ACCUM: if (close && is_b) state_d = FLUSH;
      FLUSH: begin
        if (out_hs) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q     <= '0;
      row_q     <= '0;
      pt_q      <= '0;
      err_q     <= 1'b0;
      out_vld_q <= 1'b0;
      res_q     <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        pt_q  <= pt;
        acc_q <= '0;
        row_q <= '0;
        err_q <= 1'b0;
      end
      // A misordered beat only flags the error; it neither accumulates nor closes the row.
      if (accept) begin
        if (!row_ok) begin
          err_q <= 1'b1;
        end else if (bus.in_last) begin
          acc_q      <= '0;
          row_q      <= row_q + ROW_WIDTH'(1);
          res_q.data <= acc_next + (is_b ? pt_scaled : '0);
          res_q.row  <= row_q;
          res_q.last <= is_b;
        end else begin
          acc_q <= acc_next;
        end
      end
      if (close)       out_vld_q <= 1'b1;
      else if (out_hs) out_vld_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lwe_encrypt_accum.sv
// Directed bench for lwe_encrypt_accum (LANES=2, Q=10, PT=6, ROWS=4); expected values are hand-computed.
module tb_lwe_encrypt_accum;
  localparam int LANES = 2, CT_WIDTH = 32, Q_WIDTH = 10, PT_WIDTH = 6, ROWS = 4, ROW_WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [PT_WIDTH-1:0] pt;
  logic busy, done, err;
  int n_tests = 0;
  int n_fail  = 0;

  lwe_encrypt_accum_if #(.LANES(LANES), .CT_WIDTH(CT_WIDTH), .Q_WIDTH(Q_WIDTH), .ROW_WIDTH(ROW_WIDTH)) bus ();

  lwe_encrypt_accum #(
    .LANES(LANES), .CT_WIDTH(CT_WIDTH), .Q_WIDTH(Q_WIDTH),
    .PT_WIDTH(PT_WIDTH), .ROWS(ROWS), .ROW_WIDTH(ROW_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pt(pt),
    .bus(bus), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [PT_WIDTH-1:0] p);
    start = 1'b1;
    pt    = p;
    tick();
    start = 1'b0;
  endtask

  // Presents one beat, waits (bounded) for in_ready, and returns one cycle after acceptance.
  task automatic send_beat(input int row, input int d0, input int d1, input logic [1:0] mask, input logic last);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_row   = ROW_WIDTH'(row);
    bus.in_data  = {CT_WIDTH'(d1), CT_WIDTH'(d0)};
    bus.in_mask  = mask;
    bus.in_last  = last;
    while (!bus.in_ready && waited < 50) begin
      tick();
      waited++;
    end
    check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    pt            = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mask   = '0;
    bus.in_row    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_row",   32'(bus.out_row),   32'd0);
    check("rst_out_last",  32'(bus.out_last),  32'd0);
    check("rst_done",      32'(done),          32'd0);
    check("rst_err",       32'(err),           32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    rst_n = 1'b1;
    tick();

    // Basic row, wrap, empty row, b row
    do_start(6'd3);
    check("start_busy", 32'(busy), 32'd1);
    send_beat(0, 5, 7, 2'b11, 1'b0);
    check("mid_row_no_out", 32'(bus.out_valid), 32'd0);
    send_beat(0, 1000, 30, 2'b01, 1'b1);
    check("r0_valid", 32'(bus.out_valid), 32'd1);
    check("r0_data",  32'(bus.out_data),  32'd1012);
    check("r0_row",   32'(bus.out_row),   32'd0);
    check("r0_last",  32'(bus.out_last),  32'd0);
    send_beat(1, 5, 7, 2'b11, 1'b0);
    send_beat(1, 1000, 30, 2'b11, 1'b1);
    check("r1_wrap_data", 32'(bus.out_data), 32'd18);
    check("r1_row",       32'(bus.out_row),  32'd1);
    send_beat(2, 77, 88, 2'b00, 1'b1);
    check("r2_mask0_data",  32'(bus.out_data),  32'd0);
    check("r2_mask0_valid", 32'(bus.out_valid), 32'd1);
    send_beat(3, 2, 9, 2'b01, 1'b1);
    check("b_data",  32'(bus.out_data), 32'd50);
    check("b_last",  32'(bus.out_last), 32'd1);
    check("b_row",   32'(bus.out_row),  32'd3);
    check("b_done",  32'(done),         32'd1);
    check("flush_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("post_done",  32'(done),           32'd0);
    check("post_busy",  32'(busy),           32'd0);
    check("post_valid", 32'(bus.out_valid),  32'd0);

    // Backpressure
    do_start(6'd0);
    bus.out_ready = 1'b0;
    send_beat(0, 7, 0, 2'b01, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",    32'(bus.out_valid), 32'd1);
      check("bp_data",     32'(bus.out_data),  32'd7);
      check("bp_in_ready", 32'(bus.in_ready),  32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("bp_drained", 32'(bus.out_valid), 32'd0);

    // Order error at row 1
    send_beat(2, 100, 0, 2'b01, 1'b1);
    check("oe_err",      32'(err),           32'd1);
    check("oe_no_out",   32'(bus.out_valid), 32'd0);
    send_beat(1, 4, 0, 2'b01, 1'b1);
    check("oe_next_data", 32'(bus.out_data), 32'd4);
    check("oe_next_row",  32'(bus.out_row),  32'd1);
    check("oe_sticky",    32'(err),          32'd1);
    do_start(6'd9);
    check("start_ignored_err", 32'(err), 32'd1);
    send_beat(2, 0, 0, 2'b00, 1'b1);
    send_beat(3, 0, 0, 2'b00, 1'b1);
    check("oe_b_data", 32'(bus.out_data), 32'd0);
    tick();
    do_start(6'd5);
    check("start_clears_err", 32'(err), 32'd0);

    // Reset mid-operation
    send_beat(0, 0, 0, 2'b00, 1'b1);
    send_beat(1, 0, 0, 2'b00, 1'b1);
    send_beat(7, 0, 0, 2'b01, 1'b0);
    check("pre_rst_err", 32'(err), 32'd1);
    send_beat(2, 1, 0, 2'b01, 1'b0);
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy",  32'(busy),          32'd0);
    check("mid_rst_err",   32'(err),           32'd0);
    rst_n = 1'b1;
    tick();
    do_start(6'd0);
    send_beat(0, 3, 0, 2'b01, 1'b1);
    check("restart_row",  32'(bus.out_row),  32'd0);
    check("restart_data", 32'(bus.out_data), 32'd3);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lwe_encrypt_accum.md
Name: lwe_encrypt_accum

Overview:
Streaming LWE encryption accumulator, the multi-lane successor to the single-accumulator encrypt block. Takes row-ordered beats of pre-multiplied a·s / noise terms on LANES channels with per-lane valid masks. Reduces each row sum mod 2^Q_WIDTH and adds the scaled plaintext on the final (b) row. Emits one ciphertext word per row over a valid/ready interface; sits between the operand/product engine and the ciphertext output buffer.

Parameters:
LANES, 2, parallel operand lanes per beat
CT_WIDTH, 32, width of each lane word
Q_WIDTH, 10, ciphertext modulus = 2^Q_WIDTH; requires Q_WIDTH <= CT_WIDTH
PT_WIDTH, 6, plaintext width; plaintext modulus = 2^PT_WIDTH; requires PT_WIDTH < Q_WIDTH
ROWS, 129, rows per ciphertext (DIMENSION+1; the last row is the b row)
ROW_WIDTH, 8, row index width; requires 2^ROW_WIDTH >= ROWS

Ports:
clk  in  1  clock
rst_n  in  1  reset
start  in  1  one-cycle pulse: begin a ciphertext; sampled only in IDLE
pt  in  PT_WIDTH  plaintext, captured on an accepted start
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid && in_ready
in_data  in  LANES*CT_WIDTH  lane words, lane k at bits [k*CT_WIDTH +: CT_WIDTH]
in_mask  in  LANES  1 = lane contributes
in_row  in  ROW_WIDTH  row index of the beat
in_last  in  1  final beat of the current row
out_valid  out  1  row result valid
out_ready  in  1  downstream accepts
out_data  out  Q_WIDTH  reduced row sum
out_row  out  ROW_WIDTH  row index of out_data
out_last  out  1  out_data is the b row
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when the b-row result is accepted downstream
err  out  1  sticky row-order error

Behaviour:
- Reset: clk and rst_n are decided as above; reset is synchronous, active-low. Reset forces state IDLE, accumulator 0, row counter 0, and pt register 0. Outputs reset to in_ready=0, out_valid=0, out_data=0, out_row=0, out_last=0, done=0, err=0. Reset mid-row discards all partial state with no output.
- States:
  - IDLE: start -> ACCUM; captures pt, clears accumulator, row counter and err.
  - ACCUM: accepts beats. An accepted in_last on row ROWS-1 -> FLUSH.
  - FLUSH: waits for the b-row output handshake, pulses done that cycle, then -> IDLE.
  - start outside IDLE is ignored.
- in_ready = (state==ACCUM) && (!out_valid || out_ready). This gives a single output register with pass-through backpressure and no combinational path from in_valid.
- Beat sum: sum of in_data lanes with in_mask[k]=1, taken mod 2^Q_WIDTH; only the low Q_WIDTH bits of each lane are used. acc_next = (acc + beat sum) mod 2^Q_WIDTH. in_mask=0 still advances and closes the row.
- Row order check: on an accepted beat, in_row must equal the row counter.
  - Mismatch: set err (sticky until start or reset), drop the beat, leave acc unchanged, and ignore in_last.
- Row close: on an accepted, matching beat with in_last=1:
  - out_data <= acc_next, plus (pt << (Q_WIDTH-PT_WIDTH)) mod 2^Q_WIDTH when row==ROWS-1.
  - out_row <= row counter; out_last <= (row==ROWS-1); out_valid <= 1.
  - acc <= 0; row counter +1.
  - Latency: result is visible the cycle after the closing beat.
- Output: out_valid holds with stable out_data, out_row and out_last until out_ready. A simultaneous output handshake and new row close reloads the register with no bubble.
- Wrap-around: all additions wrap mod 2^Q_WIDTH; no saturation.

Test Plan:
(Bench config: LANES=2, Q_WIDTH=10, PT_WIDTH=6, ROWS=4, out_ready=1 unless stated.)
- Basic row: start pt=3. Row 0 beat {5,7} mask 11, then beat {1000,30} mask 01 in_last -> out_data=1012, out_row=0, out_last=0, one cycle after the last beat.
- Wrap: row 1 beats {5,7} mask 11, then {1000,30} mask 11 last -> out_data=18 (1042 mod 1024). Row 2 single beat mask 00 last -> out_data=0.
- b row: row 3 beat {2,9} mask 01 last with pt=3 -> out_data=50 (2+48), out_last=1. done pulses on the handshake, then busy=0.
- Backpressure: hold out_ready=0 across a row close -> in_ready=0, out_data stable for 5 cycles. Release -> handshake, in_ready=1 the same cycle.
- Order error: in ACCUM at row 1, send in_row=2 {100,0} mask 01 last -> err=1, no output, acc unchanged. A following row-1 beat {4,0} last -> out_data=4. Next start clears err.
- Reset mid-op: assert rst_n=0 during row 2 -> next cycle out_valid=0, busy=0, err=0. start after reset begins again at row 0.
